// File: rtl/cv32e40x_pkg.sv
// Shared types, Zcmp encoding constants and RV32I encoder helpers
// for the Zcmp macro-instruction sequencer.
package cv32e40x_pkg;

  typedef enum logic {IDLE, SEQ} seq_state_e;

  typedef enum logic [2:0] {
    ZCMP_NONE,
    ZCMP_PUSH,
    ZCMP_POP,
    ZCMP_POPRET,
    ZCMP_POPRETZ,
    ZCMP_MVSA01,
    ZCMP_MVA01S
  } zcmp_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [1:0] C_OP_Q2    = 2'b10;
  localparam logic [2:0] C_F3_ZCMP  = 3'b101;
  localparam logic [4:0] ZCMP_F5_PUSH    = 5'b11000;
  localparam logic [4:0] ZCMP_F5_POP     = 5'b11010;
  localparam logic [4:0] ZCMP_F5_POPRETZ = 5'b11100;
  localparam logic [4:0] ZCMP_F5_POPRET  = 5'b11110;
  localparam logic [2:0] ZCMP_F3_MV      = 3'b011;
  localparam logic [1:0] ZCMP_MV_SA01    = 2'b01;
  localparam logic [1:0] ZCMP_MV_A01S    = 2'b11;

  localparam logic [4:0] X_ZERO = 5'd0;
  localparam logic [4:0] X_RA   = 5'd1;
  localparam logic [4:0] X_SP   = 5'd2;
  localparam logic [4:0] X_A0   = 5'd10;
  localparam logic [4:0] X_A1   = 5'd11;

  // rlist index k -> x-register: ra, s0, s1, then s2..s11 (x18..x27)
  function automatic logic [4:0] rlist_xreg(input logic [3:0] idx);
    logic [4:0] r;
    if (idx == 4'd0)      r = X_RA;
    else if (idx == 4'd1) r = 5'd8;
    else if (idx == 4'd2) r = 5'd9;
    else                  r = {1'b0, idx} + 5'd15;
    return r;
  endfunction

  function automatic logic [4:0] sreg_xreg(input logic [2:0] idx);
    logic [4:0] r;
    if (idx == 3'd0)      r = 5'd8;
    else if (idx == 3'd1) r = 5'd9;
    else                  r = {2'b00, idx} + 5'd16;
    return r;
  endfunction

  function automatic logic [3:0] nregs(input logic [3:0] rlist);
    return (rlist == 4'd15) ? 4'd13 : rlist - 4'd3;
  endfunction

  function automatic logic [11:0] stack_adj(input logic [3:0] rlist, input logic [1:0] spimm);
    logic [11:0] base;
    case (rlist[3:2])
      2'b01:   base = 12'd16;
      2'b10:   base = 12'd32;
      default: base = (rlist == 4'd15) ? 12'd64 : 12'd48;
    endcase
    return base + {6'b0, spimm, 4'b0};
  endfunction

  function automatic logic [4:0] num_ops(input zcmp_op_e op, input logic [3:0] rlist);
    logic [4:0] nr;
    logic [4:0] n;
    nr = {1'b0, nregs(rlist)};
    case (op)
      ZCMP_PUSH, ZCMP_POP:        n = nr + 5'd1;
      ZCMP_POPRET:                n = nr + 5'd2;
      ZCMP_POPRETZ:               n = nr + 5'd3;
      ZCMP_MVSA01, ZCMP_MVA01S:   n = 5'd2;
      default:                    n = 5'd1;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

endpackage

// File: rtl/cv32e40x_zcmp_instr_gen.sv
// Combinational micro-op generator: builds the RV32I instruction for
// step cnt of a decoded Zcmp macro.
module cv32e40x_zcmp_instr_gen
  import cv32e40x_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [3:0]  rlist,
  input  logic [1:0]  spimm,
  input  logic [2:0]  r1s,
  input  logic [2:0]  r2s,
  input  logic [3:0]  cnt,
  output logic [31:0] instr
);

  zcmp_op_e    op_e;
  logic [3:0]  nr;
  logic [11:0] adj;
  logic [11:0] off;

  assign op_e = zcmp_op_e'(op);
  assign nr   = nregs(rlist);
  assign adj  = stack_adj(rlist, spimm);
  assign off  = {6'b0, cnt, 2'b00} + 12'd4;

  always_comb begin
    instr = '0;
    case (op_e)
      ZCMP_PUSH: begin
        if (cnt < nr) instr = enc_s(12'd0 - off, rlist_xreg(cnt), X_SP, F3_WORD, OPC_STORE);
        else          instr = enc_i(12'd0 - adj, X_SP, F3_ADDI, X_SP, OPC_OPIMM);
      end
      ZCMP_POP, ZCMP_POPRET, ZCMP_POPRETZ: begin
        if (cnt < nr)
          instr = enc_i(adj - off, X_SP, F3_WORD, rlist_xreg(cnt), OPC_LOAD);
        else if (cnt == nr)
          instr = enc_i(adj, X_SP, F3_ADDI, X_SP, OPC_OPIMM);
        else if (op_e == ZCMP_POPRETZ && cnt == nr + 4'd1)
          instr = enc_i(12'd0, X_ZERO, F3_ADDI, X_A0, OPC_OPIMM);
        else
          instr = enc_i(12'd0, X_RA, F3_JALR, X_ZERO, OPC_JALR);
      end
      ZCMP_MVSA01: begin
        if (cnt == 4'd0) instr = enc_i(12'd0, X_A0, F3_ADDI, sreg_xreg(r1s), OPC_OPIMM);
        else             instr = enc_i(12'd0, X_A1, F3_ADDI, sreg_xreg(r2s), OPC_OPIMM);
      end
      ZCMP_MVA01S: begin
        if (cnt == 4'd0) instr = enc_i(12'd0, sreg_xreg(r1s), F3_ADDI, X_A0, OPC_OPIMM);
        else             instr = enc_i(12'd0, sreg_xreg(r2s), F3_ADDI, X_A1, OPC_OPIMM);
      end
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/cv32e40x_zcmp_sequencer.sv
// Expands Zcmp push/pop/mv macros into RV32I micro-ops between IF/ID and
// the decoder; everything else passes through with zero latency.
module cv32e40x_zcmp_sequencer
  import cv32e40x_pkg::*;
#(
  parameter bit ZCMP_EN = 1'b1,
  parameter bit RV32E   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        instr_compressed_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        first_op_o,
  output logic        last_op_o,
  output logic        seq_active_o,
  output logic        illegal_o,
  input  logic        kill_i
);

  seq_state_e  state;
  logic [3:0]  cnt;
  logic [15:0] c;
  zcmp_op_e    op;
  logic [3:0]  rlist;
  logic [1:0]  spimm;
  logic [2:0]  r1s;
  logic [2:0]  r2s;
  logic        is_pushpop;
  logic        reserved;
  logic        is_zcmp;
  logic [4:0]  n_ops;
  logic [31:0] gen_instr;
  logic        last;
  logic        hs;

  assign c     = instr_i[15:0];
  assign rlist = c[7:4];
  assign spimm = c[3:2];
  assign r1s   = c[9:7];
  assign r2s   = c[4:2];

  // Detection only applies to 16-bit encodings so 32-bit aliases pass through
  always_comb begin
    op = ZCMP_NONE;
    if (ZCMP_EN && instr_compressed_i && c[1:0] == C_OP_Q2 && c[15:13] == C_F3_ZCMP) begin
      if (c[12:8] == ZCMP_F5_PUSH)         op = ZCMP_PUSH;
      else if (c[12:8] == ZCMP_F5_POP)     op = ZCMP_POP;
      else if (c[12:8] == ZCMP_F5_POPRETZ) op = ZCMP_POPRETZ;
      else if (c[12:8] == ZCMP_F5_POPRET)  op = ZCMP_POPRET;
      else if (c[12:10] == ZCMP_F3_MV && c[6:5] == ZCMP_MV_SA01) op = ZCMP_MVSA01;
      else if (c[12:10] == ZCMP_F3_MV && c[6:5] == ZCMP_MV_A01S) op = ZCMP_MVA01S;
    end
  end

  assign is_pushpop = (op == ZCMP_PUSH) || (op == ZCMP_POP) ||
                      (op == ZCMP_POPRET) || (op == ZCMP_POPRETZ);
  assign reserved   = is_pushpop && ((rlist < 4'd4) || (RV32E && (rlist > 4'd6)));
  assign is_zcmp    = (op != ZCMP_NONE) && !reserved;
  assign n_ops      = num_ops(op, rlist);

  cv32e40x_zcmp_instr_gen u_instr_gen (
    .op    (op),
    .rlist (rlist),
    .spimm (spimm),
    .r1s   (r1s),
    .r2s   (r2s),
    .cnt   (cnt),
    .instr (gen_instr)
  );

  assign last = (state == IDLE) ? !is_zcmp : ({1'b0, cnt} == n_ops - 5'd1);
  assign hs   = valid_i && ready_i && !kill_i;

  assign valid_o    = valid_i && !kill_i;
  assign ready_o    = hs && last;
  assign first_op_o = (state == IDLE);
  assign last_op_o  = last;
  assign illegal_o  = valid_i && reserved;
  assign instr_o    = (state == SEQ || is_zcmp) ? gen_instr : instr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      seq_active_o <= 1'b0;
    end else if (!ZCMP_EN || kill_i) begin
      state        <= IDLE;
      cnt          <= '0;
      seq_active_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs && is_zcmp) begin
            state        <= SEQ;
            cnt          <= 4'd1;
            seq_active_o <= 1'b1;
          end
        end
        SEQ: begin
          if (hs) begin
            if (last) begin
              state        <= IDLE;
              cnt          <= '0;
              seq_active_o <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          seq_active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40x_zcmp_sequencer.sv
// Directed self-checking bench for the Zcmp sequencer.
module tb_cv32e40x_zcmp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic        instr_compressed_i;
  logic        valid_i;
  logic        ready_i;
  logic        kill_i;

  logic        ready_o, valid_o, first_op_o, last_op_o, seq_active_o, illegal_o;
  logic [31:0] instr_o;
  logic        p_ready_o, p_valid_o, p_first_op_o, p_last_op_o, p_seq_active_o, p_illegal_o;
  logic [31:0] p_instr_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cv32e40x_zcmp_sequencer u_dut (
    .clk                (clk),
    .rst                (rst),
    .instr_i            (instr_i),
    .instr_compressed_i (instr_compressed_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .instr_o            (instr_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .first_op_o         (first_op_o),
    .last_op_o          (last_op_o),
    .seq_active_o       (seq_active_o),
    .illegal_o          (illegal_o),
    .kill_i             (kill_i)
  );

  cv32e40x_zcmp_sequencer #(.ZCMP_EN(1'b0), .RV32E(1'b0)) u_dut_pt (
    .clk                (clk),
    .rst                (rst),
    .instr_i            (instr_i),
    .instr_compressed_i (instr_compressed_i),
    .valid_i            (valid_i),
    .ready_o            (p_ready_o),
    .instr_o            (p_instr_o),
    .valid_o            (p_valid_o),
    .ready_i            (ready_i),
    .first_op_o         (p_first_op_o),
    .last_op_o          (p_last_op_o),
    .seq_active_o       (p_seq_active_o),
    .illegal_o          (p_illegal_o),
    .kill_i             (kill_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] ins,
                           input logic first, input logic last, input logic rdy);
    check({tag, ".instr"}, instr_o, ins);
    check({tag, ".valid"}, {31'b0, valid_o}, 32'd1);
    check({tag, ".first"}, {31'b0, first_op_o}, {31'b0, first});
    check({tag, ".last"},  {31'b0, last_op_o},  {31'b0, last});
    check({tag, ".ready"}, {31'b0, ready_o},    {31'b0, rdy});
  endtask

  // Drives one macro with ready_i=1 and checks it against exp_q
  task automatic run_macro(input string tag, input logic [15:0] cinstr);
    int n;
    n = exp_q.size();
    instr_i = {16'b0, cinstr};
    instr_compressed_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    #1;
    for (int i = 0; i < n; i++) begin
      expect_op($sformatf("%s.op%0d", tag, i), exp_q[i], i == 0, i == n - 1, i == n - 1);
      if (i == 1) check({tag, ".seq_active"}, {31'b0, seq_active_o}, 32'd1);
      tick();
    end
    check({tag, ".done_seq_active"}, {31'b0, seq_active_o}, 32'd0);
    valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr_i = '0;
    instr_compressed_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    kill_i = 1'b0;
    #2;
    check("rst.valid",      {31'b0, valid_o},      32'd0);
    check("rst.ready",      {31'b0, ready_o},      32'd0);
    check("rst.first",      {31'b0, first_op_o},   32'd1);
    check("rst.last",       {31'b0, last_op_o},    32'd1);
    check("rst.illegal",    {31'b0, illegal_o},    32'd0);
    check("rst.seq_active", {31'b0, seq_active_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    exp_q = '{32'hFE112E23, 32'hFE812C23, 32'hFE912A23, 32'hFF010113};
    run_macro("push", 16'hB862);

    exp_q = '{32'h00C12083, 32'h01010113, 32'h00008067};
    run_macro("popret", 16'hBE42);

    exp_q = '{32'h01C12083, 32'h01812403, 32'h02010113, 32'h00000513, 32'h00008067};
    run_macro("popretz", 16'hBC56);

    exp_q = '{32'h00050413, 32'h00058913};
    run_macro("mvsa01", 16'hAC2A);

    // Stall at cnt=2 of push
    instr_i = 32'h0000B862;
    instr_compressed_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    tick();
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_op($sformatf("stall.c%0d", i), 32'hFE912A23, 1'b0, 1'b0, 1'b0);
      check("stall.seq_active", {31'b0, seq_active_o}, 32'd1);
      tick();
    end
    ready_i = 1'b1;
    #1;
    expect_op("stall.resume", 32'hFE912A23, 1'b0, 1'b0, 1'b0);
    tick();
    expect_op("stall.final", 32'hFF010113, 1'b0, 1'b1, 1'b1);
    tick();
    check("stall.done", {31'b0, seq_active_o}, 32'd0);

    // Kill at cnt=1 of push
    tick();
    check("kill.cnt1", instr_o, 32'hFE812C23);
    kill_i = 1'b1;
    #1;
    check("kill.valid", {31'b0, valid_o}, 32'd0);
    check("kill.ready", {31'b0, ready_o}, 32'd0);
    tick();
    kill_i = 1'b0;
    check("kill.seq_active", {31'b0, seq_active_o}, 32'd0);
    instr_i = 32'h00100093;
    instr_compressed_i = 1'b0;
    #1;
    expect_op("kill.next", 32'h00100093, 1'b1, 1'b1, 1'b1);
    tick();

    // Reserved rlist
    instr_i = 32'h0000B802;
    instr_compressed_i = 1'b1;
    #1;
    check("rsv.illegal", {31'b0, illegal_o}, 32'd1);
    expect_op("rsv", 32'h0000B802, 1'b1, 1'b1, 1'b1);
    tick();
    check("rsv.seq_active", {31'b0, seq_active_o}, 32'd0);

    // 32-bit instruction aliasing a Zcmp pattern in its low half
    instr_i = 32'h0000B862;
    instr_compressed_i = 1'b0;
    #1;
    check("alias.illegal", {31'b0, illegal_o}, 32'd0);
    expect_op("alias", 32'h0000B862, 1'b1, 1'b1, 1'b1);
    tick();
    check("alias.seq_active", {31'b0, seq_active_o}, 32'd0);

    // Reset at cnt=2 of popret
    instr_i = 32'h0000BE42;
    instr_compressed_i = 1'b1;
    tick();
    tick();
    check("rstmid.cnt2", instr_o, 32'h00008067);
    rst = 1'b1;
    #1;
    check("rstmid.seq_active", {31'b0, seq_active_o}, 32'd0);
    check("rstmid.first", {31'b0, first_op_o}, 32'd1);
    check("rstmid.instr", instr_o, 32'h00C12083);
    valid_i = 1'b0;
    #1;
    check("rstmid.valid", {31'b0, valid_o}, 32'd0);
    check("rstmid.ready", {31'b0, ready_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Pass-through instance with Zcmp disabled
    instr_i = 32'h0000B862;
    instr_compressed_i = 1'b1;
    valid_i = 1'b1;
    #1;
    check("pt.instr",   p_instr_o, 32'h0000B862);
    check("pt.illegal", {31'b0, p_illegal_o}, 32'd0);
    check("pt.ready",   {31'b0, p_ready_o}, 32'd1);
    check("pt.last",    {31'b0, p_last_op_o}, 32'd1);
    tick();
    check("pt.seq_active", {31'b0, p_seq_active_o}, 32'd0);
    check("pt.instr2", p_instr_o, 32'h0000B862);
    instr_i = 32'h0000B802;
    #1;
    check("pt.rsv_illegal", {31'b0, p_illegal_o}, 32'd0);
    valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
